dec_lut_req_sched: RTL and testbench
====================================

// Module: dec_lut_req_sched
// PURPOSE
//  Shares one clocked DEC_LUT decoder (W in, N/found out) between NUM_REQ requesters.
//  Round-robin arbitration, one lookup in flight, tagged response channel, timeout on a missing found.
//  Sits between client engines and the decoder instance.
//  Holds dec_w stable for the whole lookup, as the decoder requires.
// PARAMETERS
//  NUM_REQ   4     number of requesters (>=2)
//  W_BITS    39    decoder input width
//  N_BITS    25    decoder result width
//  TIMEOUT   4096  WAIT cycles without dec_found before abort (>=2)
//  TMO_W     13    timeout counter width, must hold TIMEOUT
// PORTS
//  clk        in   1               single clock, rising edge
//  rst_n      in   1               asynchronous reset, active-low
//  req_valid  in   NUM_REQ         per-requester request valid
//  req_ready  out  NUM_REQ         per-requester accept (one-hot or zero)
//  req_w      in   NUM_REQ*W_BITS  request words; requester i at [i*W_BITS +: W_BITS]
//  rsp_valid  out  1               response valid
//  rsp_ready  in   1               response accept
//  rsp_id     out  $clog2(NUM_REQ) index of requester being answered
//  rsp_n      out  N_BITS          decoded N (0 on error)
//  rsp_err    out  1               1 = timeout, no result
//  dec_w      out  W_BITS          decoder input, registered
//  dec_start  out  1               1-cycle pulse: start search on dec_w
//  dec_abort  out  1               1-cycle pulse: abandon search
//  dec_found  in   1               decoder result valid
//  dec_n      in   N_BITS          decoder result
//  busy       out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset:
//   - async on rst_n low: state=IDLE, rr_ptr=0, tmo_cnt=0
//   - all outputs 0, dec_w=0
//   - mid-operation reset drops the lookup; no response is issued
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE:
//   - IDLE: grant g = first i with req_valid[i], searching from rr_ptr upward with wrap
//     - same cycle: req_ready[g]=1 (combinational on req_valid); capture req_w[g] and id
//     - next: rr_ptr<=(g+1)%NUM_REQ, go ISSUE; no valid requester -> stay IDLE
//   - ISSUE: dec_w updated from capture on entry; dec_start=1 for this one cycle; tmo_cnt<=0; go WAIT
//   - WAIT: dec_found high -> latch dec_n, rsp_err<=0, go RESP
//     - else tmo_cnt++; tmo_cnt==TIMEOUT-1 -> dec_abort pulse, rsp_n<=0, rsp_err<=1, go RESP
//     - dec_found on the timeout cycle wins: normal result, no abort
//   - RESP: rsp_valid=1; rsp_id/rsp_n/rsp_err stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE
//  Rules:
//   - dec_found outside WAIT is ignored
//   - req_ready is 0 outside IDLE
//   - no new grant in the handshake cycle; next accept is the cycle after
//   - latency: accept at T -> dec_start at T+1; dec_found at F -> rsp_valid at F+1
//   - back-to-back minimum: 4 cycles per request with found the cycle after start
//   - rr_ptr advances only on grant
//   - a requester dropping req_valid unaccepted is legal; it is not tracked
// STRUCTURE
//  Package dec_lut_sched_pkg: FSM state enum (IDLE/ISSUE/WAIT/RESP), ID_W=$clog2(NUM_REQ) helper.
//  Sub-module dec_lut_rr_arb: combinational round-robin pick (req vector, rr_ptr -> one-hot grant, index, any).
//  FSM, capture registers and timeout counter stay in dec_lut_req_sched.
// TESTING (behavioural decoder model with programmable found latency, N returned = 16777215)
//  Single request:
//   - req 0 W=123456789, latency 3 -> dec_start at T+1, rsp at T+5
//   - rsp_id=0, rsp_n=16777215, rsp_err=0
//  Fairness:
//   - all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1
//   - each request issued exactly once
//  Timeout:
//   - TIMEOUT=16, model never asserts found -> dec_abort 16 cycles after dec_start
//   - rsp_err=1, rsp_n=0; next request proceeds normally
//  Found on timeout cycle:
//   - found asserted exactly at tmo_cnt==TIMEOUT-1 -> rsp_err=0, no dec_abort
//  Backpressure:
//   - rsp_ready low 10 cycles -> rsp_* stable, req_ready all 0
//   - next grant only after the handshake
//  Reset mid-WAIT:
//   - rst_n low 5 ns during WAIT -> outputs 0 immediately, no stale response
//   - fresh request after reset is served by requester 0 first
//  Stray found: dec_found pulsed in IDLE -> no rsp_valid

Source files
------------

// File: rtl/dec_lut_sched_pkg.sv
// Shared types and helpers for the DEC_LUT request scheduler.
package dec_lut_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_t;

   localparam int NUM_REQ_DEF = 4;

   // Requester index width; a single requester still gets a 1-bit id.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dec_lut_rr_arb.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module dec_lut_rr_arb
   import dec_lut_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   logic [ID_W-1:0] w_pos;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_pos = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = ID_W'((int'(i_ptr) + k) % NUM_REQ);
         if (!o_any && i_req[w_pos]) begin
            o_any        = 1'b1;
            o_idx        = w_pos;
            o_gnt[w_pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dec_lut_req_sched.sv
// Shares one DEC_LUT decoder between NUM_REQ requesters: round-robin grant,
// one lookup in flight, tagged response, timeout abort on a missing found.
//
// state    | meaning
// ST_IDLE  | waiting for any req_valid; grant and capture in the same cycle
// ST_ISSUE | dec_w holds the captured word, dec_start pulses
// ST_WAIT  | waiting for dec_found, timeout counter running
// ST_RESP  | rsp_valid held until rsp_ready
module dec_lut_req_sched
   import dec_lut_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int W_BITS  = 39,
   parameter int N_BITS  = 25,
   parameter int TIMEOUT = 4096,
   parameter int TMO_W   = 13
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*W_BITS-1:0]  req_w,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [id_w(NUM_REQ)-1:0]   rsp_id,
   output logic [N_BITS-1:0]          rsp_n,
   output logic                       rsp_err,
   output logic [W_BITS-1:0]          dec_w,
   output logic                       dec_start,
   output logic                       dec_abort,
   input  logic                       dec_found,
   input  logic [N_BITS-1:0]          dec_n,
   output logic                       busy
);

   localparam int ID_W = id_w(NUM_REQ);

   sched_state_t      r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_rsp_id;
   logic [TMO_W-1:0]  r_tmo_cnt;
   logic [W_BITS-1:0] r_dec_w;
   logic [N_BITS-1:0] r_rsp_n;
   logic              r_rsp_err;

   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_gnt_idx;
   logic [ID_W-1:0]    w_ptr_next;
   logic               w_any;
   logic               w_tmo_hit;
   logic [W_BITS-1:0]  w_sel_w;

   dec_lut_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx),
      .o_any (w_any)
   );

   // One-hot AND-OR mux of the granted request word.
   always_comb begin
      w_sel_w = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) w_sel_w = w_sel_w | req_w[i*W_BITS +: W_BITS];
      end
   end

   assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
   assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_rr_ptr  <= '0;
         r_rsp_id  <= '0;
         r_tmo_cnt <= '0;
         r_dec_w   <= '0;
         r_rsp_n   <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_dec_w  <= w_sel_w;
                  r_rsp_id <= w_gnt_idx;
                  r_rr_ptr <= w_ptr_next;
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_tmo_cnt <= '0;
               r_state   <= ST_WAIT;
            end
            ST_WAIT: begin
               // A found arriving on the last allowed cycle still counts as a result.
               if (dec_found) begin
                  r_rsp_n   <= dec_n;
                  r_rsp_err <= 1'b0;
                  r_state   <= ST_RESP;
               end else if (w_tmo_hit) begin
                  r_rsp_n   <= '0;
                  r_rsp_err <= 1'b1;
                  r_state   <= ST_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Gated by rst_n so every output reads 0 while reset is held.
   assign req_ready = (rst_n && r_state == ST_IDLE) ? w_gnt : '0;
   assign dec_start = (r_state == ST_ISSUE);
   assign dec_abort = (r_state == ST_WAIT) && !dec_found && w_tmo_hit;
   assign rsp_valid = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);
   assign dec_w     = r_dec_w;
   assign rsp_id    = r_rsp_id;
   assign rsp_n     = r_rsp_n;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dec_lut_req_sched.sv
// Bench for dec_lut_req_sched: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the scheduler.
module tb_dec_lut_req_sched;

   localparam int NREQ = 4;
   localparam int WB   = 39;
   localparam int NB   = 25;
   localparam int TMO  = 16;
   localparam int TW   = 5;
   localparam logic [NB-1:0] NFULL = 25'd16777215;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*WB-1:0]   req_w;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_id;
   logic [NB-1:0]        rsp_n;
   logic                 rsp_err;
   logic [WB-1:0]        dec_w;
   logic                 dec_start;
   logic                 dec_abort;
   logic                 dec_found = 1'b0;
   logic [NB-1:0]        dec_n = '0;
   logic                 busy;

   dec_lut_req_sched #(
      .NUM_REQ(NREQ), .W_BITS(WB), .N_BITS(NB), .TIMEOUT(TMO), .TMO_W(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_w(req_w), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_n(rsp_n), .rsp_err(rsp_err), .dec_w(dec_w), .dec_start(dec_start),
      .dec_abort(dec_abort), .dec_found(dec_found), .dec_n(dec_n), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int oh2i(input logic [NREQ-1:0] v);
      int r;
      r = -1;
      for (int k = NREQ - 1; k >= 0; k--) if (((v >> k) & 4'd1) != 4'd0) r = k;
      return r;
   endfunction

   function automatic logic [WB-1:0] rand_w();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[WB-1:0];
   endfunction

   function automatic logic [WB-1:0] slice_w(input logic [NREQ*WB-1:0] v, input int i);
      return WB'(v >> (i * WB));
   endfunction

   task automatic set_w(input int id, input logic [WB-1:0] w);
      logic [NREQ*WB-1:0] m;
      m = (NREQ*WB)'({WB{1'b1}}) << (id * WB);
      req_w = (req_w & ~m) | ((NREQ*WB)'(w) << (id * WB));
   endtask

   // Decoder model: found pulses lat_cfg cycles after dec_start; negative = never.
   int            lat_cfg = 3;
   int            dly = -1;
   logic          stray = 1'b0;
   logic [NB-1:0] n_cfg = NFULL;

   always @(posedge clk) begin
      logic f;
      #1;
      f = 1'b0;
      if (dec_start) dly = lat_cfg;
      else if (dly > 0) begin
         dly = dly - 1;
         if (dly == 0) f = 1'b1;
      end
      dec_found = f | stray;
      dec_n     = n_cfg;
   end

   // Scheduler model: one lookup tracked by its age in cycles since the grant.
   int            m_ptr, m_age, g, waited;
   bit            m_inflight, m_pend, win, exp_busy, exp_abort, prev_rv;
   logic [1:0]    m_id, jj;
   logic [WB-1:0] m_w;
   logic [NB-1:0] m_n;
   logic          m_err;
   logic [NREQ-1:0] exp_rr;
   int            q_gnt[$];
   int            t_acc, t_start, t_abort, n_abort = 0, n_start = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_ptr = 0; m_age = 0; m_inflight = 0; m_pend = 0; prev_rv = 0;
         m_id = '0; m_w = '0; m_n = '0; m_err = 1'b0;
      end else begin
         exp_busy = m_inflight || m_pend;
         g = -1;
         if (!exp_busy) begin
            for (int k = 0; k < NREQ; k++) begin
               jj = 2'((m_ptr + k) % NREQ);
               if (g < 0 && ((req_valid >> jj) & 4'd1) != 4'd0) g = int'(jj);
            end
         end
         exp_rr    = (g >= 0) ? (4'd1 << g) : 4'd0;
         win       = m_inflight && m_age >= 2;
         waited    = m_age - 2;
         exp_abort = win && !dec_found && waited == TMO - 1;
         chk("req_ready", req_ready, exp_rr);
         chk("busy", busy, exp_busy);
         chk("dec_start", dec_start, m_inflight && m_age == 1);
         chk("dec_abort", dec_abort, exp_abort);
         chk("rsp_valid", rsp_valid, m_pend);
         chk("dec_w", dec_w, m_w);
         if (m_pend) chk("rsp_fields", {rsp_id, rsp_n, rsp_err}, {m_id, m_n, m_err});
         if (req_ready != 0) begin t_acc = cyc; q_gnt.push_back(oh2i(req_ready)); end
         if (dec_start) begin t_start = cyc; n_start++; end
         if (dec_abort) begin t_abort = cyc; n_abort++; end
         prev_rv = rsp_valid;
         if (g >= 0) begin
            m_inflight = 1; m_age = 1; m_id = 2'(g);
            m_w = slice_w(req_w, g); m_ptr = (g + 1) % NREQ;
         end else if (m_inflight) begin
            if (win && dec_found) begin
               m_pend = 1; m_n = dec_n; m_err = 1'b0; m_inflight = 0;
            end else if (win && waited == TMO - 1) begin
               m_pend = 1; m_n = '0; m_err = 1'b1; m_inflight = 0;
            end else m_age++;
         end else if (m_pend && rsp_ready) m_pend = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic do_req(input int id, input logic [WB-1:0] w, input int lat);
      bit ok;
      ok = 0;
      lat_cfg = lat;
      set_w(id, w);
      req_valid = req_valid | (4'd1 << id);
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (((req_ready >> id) & 4'd1) != 4'd0) ok = 1;
      end
      chk("accept", ok, 1);
      tick();
      req_valid = req_valid & ~(4'd1 << id);
   endtask

   task automatic wait_rsp(input int budget, output int at);
      bit seen;
      seen = 0;
      at = -1;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) begin seen = 1; at = cyc; end
      end
      chk("rsp_arrives", seen, 1);
   endtask

   task automatic wait_idle(input int budget);
      bit idle;
      idle = 0;
      for (int k = 0; k < budget && !idle; k++) begin
         @(negedge clk);
         if (!busy) idle = 1;
      end
      chk("drain_idle", idle, 1);
   endtask

   int exp_order[6] = '{0, 1, 2, 3, 0, 1};
   int rc, hs, acc, na, ns0;
   bit got;

   initial begin
      rst_n = 1'b1; req_valid = '0; req_w = '0; rsp_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ctrl", {busy, rsp_valid, dec_start, dec_abort, req_ready}, 0);
      chk("reset_dec_w", dec_w, 0);
      chk("reset_rsp", {rsp_id, rsp_n, rsp_err}, 0);

      // Fairness: all four requesting continuously.
      tick();
      lat_cfg = 1;
      q_gnt.delete();
      ns0 = n_start;
      for (int i = 0; i < NREQ; i++) set_w(i, rand_w());
      req_valid = 4'hF;
      for (int k = 0; k < 60 && q_gnt.size() < 6; k++) @(negedge clk);
      tick();
      req_valid = '0;
      wait_idle(20);
      chk("fair_count", q_gnt.size(), 6);
      for (int i = 0; i < 6; i++) chk("fair_order", (i < q_gnt.size()) ? q_gnt[i] : -1, exp_order[i]);
      chk("fair_starts", n_start - ns0, 6);

      // Single request with decoder latency 3.
      tick();
      do_req(0, 39'd123456789, 3);
      wait_rsp(20, rc);
      chk("single_start_lat", t_start - t_acc, 1);
      chk("single_rsp_lat", rc - t_acc, 5);
      chk("single_rsp", {rsp_id, rsp_n, rsp_err}, {2'd0, NFULL, 1'b0});
      chk("single_dec_w", dec_w, 39'd123456789);
      tick();

      // Timeout, then a normal request.
      do_req(3, rand_w(), -1);
      wait_rsp(40, rc);
      chk("tmo_abort_lat", t_abort - t_start, 16);
      chk("tmo_rsp", {rsp_id, rsp_n, rsp_err}, {2'd3, 25'd0, 1'b1});
      tick();
      do_req(1, rand_w(), 2);
      wait_rsp(20, rc);
      chk("after_tmo_rsp", {rsp_id, rsp_n, rsp_err}, {2'd1, NFULL, 1'b0});
      tick();

      // Found exactly on the last timeout cycle.
      na = n_abort;
      do_req(2, rand_w(), 16);
      wait_rsp(40, rc);
      chk("edge_rsp", {rsp_id, rsp_n, rsp_err}, {2'd2, NFULL, 1'b0});
      chk("edge_no_abort", n_abort - na, 0);
      chk("edge_rsp_lat", rc - t_start, 17);
      tick();

      // Backpressure with another requester waiting.
      rsp_ready = 1'b0;
      do_req(1, rand_w(), 2);
      set_w(2, rand_w());
      req_valid = 4'b0100;
      wait_rsp(20, rc);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_hold", {rsp_valid, rsp_id, rsp_n, rsp_err, req_ready}, {1'b1, 2'd1, NFULL, 1'b0, 4'd0});
      end
      tick();
      rsp_ready = 1'b1;
      hs = cyc;
      got = 0;
      acc = -1;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (req_ready[2]) begin got = 1; acc = cyc; end
      end
      chk("bp_next_grant", acc - hs, 1);
      tick();
      req_valid = '0;
      wait_rsp(20, rc);
      tick();

      // Stray found while idle.
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stray_quiet", {rsp_valid, busy}, 0);
      end

      // Reset in the middle of a lookup.
      tick();
      do_req(2, rand_w(), -1);
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {busy, rsp_valid, dec_start, dec_abort, req_ready}, 0);
      chk("midrst_dec_w", dec_w, 0);
      chk("midrst_rsp", {rsp_id, rsp_n, rsp_err}, 0);
      #4 rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("midrst_no_rsp", rsp_valid, 0);
      end
      tick();
      lat_cfg = 1;
      req_valid = 4'hF;
      got = 0;
      acc = -1;
      for (int k = 0; k < 5 && !got; k++) begin
         @(negedge clk);
         if (req_ready != 0) begin got = 1; acc = oh2i(req_ready); end
      end
      chk("midrst_first_grant", acc, 0);
      tick();
      req_valid = '0;
      wait_rsp(20, rc);
      tick();

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         req_valid = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         for (int i = 0; i < NREQ; i++) set_w(i, rand_w());
         rsp_ready = ($urandom_range(0, 3) != 0);
         lat_cfg   = $urandom_range(1, 20);
         n_cfg     = NB'($urandom());
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
